// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Sequencing FSM for a multicycle MIPS32 datapath. The PC, instruction
// register, register file, ALU and data memory are shared across cycles. This
// block decodes the opcode and drives the per-cycle enables and mux selects. It
// holds in the memory states until the memory acknowledges, supports run/stop
// control, and traps on illegal opcodes.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   run            1 = execute; sampled in IDLE and at each instruction end
//   opcode         instr[31:26] from the instruction register
//   zero           ALU zero flag (the datapath combines it with pc_write_cond)
//   mem_ready      memory acknowledges the current read or write this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if zero
//   pc_source      00 ALU result, 01 ALUOut reg, 10 jump target
//   i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       instruction register load
//   reg_dst        1 = rd, 0 = rt
//   mem_to_reg     1 = memory data register, 0 = ALUOut
//   reg_write      register file write enable
//   alu_src_a      0 = PC, 1 = register A
//   alu_src_b      00 = register B, 01 = constant 1, 10 = sign-extended imm
//   alu_op         00 add, 01 sub, 10 funct-decoded
//   trap           illegal-opcode halt indicator
//   busy           1 in every state except IDLE and TRAP
//   instr_count    instructions fetched since reset (wraps)
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_J     = 6'h02,
   parameter logic [5:0] OP_ADDI  = 6'h08
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_source,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        trap,
   output logic        busy,
   output logic [31:0] instr_count
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_JUMP   = 4'd10;
   localparam logic [3:0] S_ADDIEX = 4'd11;
   localparam logic [3:0] S_ADDIWB = 4'd12;
   localparam logic [3:0] S_TRAP   = 4'd13;

   logic [3:0] state;
   logic [3:0] next_state;
   logic [3:0] end_target;

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values; the combinational blocks below use blocking ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         instr_count <= '0;
      end else begin
         state <= next_state;
         if (state == S_FETCH && mem_ready)
            instr_count <= instr_count + 32'd1;
      end
   end

   // run is only consulted when an instruction retires, never mid-instruction.
   assign end_target = run ? S_FETCH : S_IDLE;

   always_comb begin
      // NOTE: default first so every path assigns next_state (no latch).
      next_state = state;
      case (state)
         S_IDLE:   if (run) next_state = S_FETCH;
         S_FETCH:  if (mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = S_EXEC;
               OP_BEQ:       next_state = S_BRANCH;
               OP_J:         next_state = S_JUMP;
               OP_ADDI:      next_state = S_ADDIEX;
               default:      next_state = S_TRAP;
            endcase
         end
         S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
         S_MEMWR:  if (mem_ready) next_state = end_target;
         S_EXEC:   next_state = S_ALUWB;
         S_ADDIEX: next_state = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB:
                   next_state = end_target;
         S_TRAP:   next_state = S_TRAP;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      trap          = (state == S_TRAP);
      busy          = (state != S_IDLE) && (state != S_TRAP);
      case (state)
         S_FETCH: begin
            // PC + 1 is computed every fetch cycle; it is only committed,
            // together with the IR load, once memory acknowledges.
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: alu_src_b = 2'b10;   // precompute branch target
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB: reg_write = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Randomized bench for multicycle_control. The driver issues one instruction at
// a time (opcode, memory wait counts, run behaviour) and pushes the expected
// per-instruction summary, computed from the instruction's phase list, into a
// scoreboard queue. An independent monitor watches the DUT every cycle,
// delimits instructions by the start of each fetch, accumulates what it saw,
// and compares against the popped expectation. Idle/trap/reset cycles are
// checked for quiet outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // Per-cycle datapath setup {trap, alu_src_a, alu_src_b, alu_op, i_or_d}
   localparam logic [6:0] C_NONE   = 7'b0000000;
   localparam logic [6:0] C_FETCH  = 7'b0001000;
   localparam logic [6:0] C_DECODE = 7'b0010000;
   localparam logic [6:0] C_MEMADR = 7'b0110000;
   localparam logic [6:0] C_MEMIO  = 7'b0000001;
   localparam logic [6:0] C_EXEC   = 7'b0100100;
   localparam logic [6:0] C_BRANCH = 7'b0100010;
   localparam logic [6:0] C_ADDIEX = 7'b0110000;

   logic        clk = 1'b0;
   logic        rst, run, zero, mem_ready;
   logic [5:0]  opcode;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a, trap, busy;
   logic [1:0]  pc_source, alu_src_b, alu_op;
   logic [31:0] instr_count;

   multicycle_control dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .busy(busy),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cycles;
      int unsigned ir_writes;
      int unsigned pc_writes;
      int unsigned cond_writes;
      int unsigned reg_writes;
      int unsigned dst_cycles;
      int unsigned m2r_cycles;
      int unsigned src_sum;
      int unsigned mem_reads;
      int unsigned mem_writes;
      int unsigned ctrl_sig;
      int unsigned count;
      int unsigned trap;
   } rec_t;

   rec_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int unsigned model_n  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: an instruction is a list of phases, each with a fixed datapath
   // setup; the summary counters follow from the opcode's rules.
   function automatic rec_t model(input logic [5:0] op, input int wf, input int wd,
                                  input int unsigned n);
      rec_t       r;
      logic [6:0] ph[$];
      r = '{default: 0};
      for (int i = 0; i <= wf; i++) ph.push_back(C_FETCH);
      ph.push_back(C_DECODE);
      case (op)
         OP_LW: begin
            ph.push_back(C_MEMADR);
            for (int i = 0; i <= wd; i++) ph.push_back(C_MEMIO);
            ph.push_back(C_NONE);
         end
         OP_SW: begin
            ph.push_back(C_MEMADR);
            for (int i = 0; i <= wd; i++) ph.push_back(C_MEMIO);
         end
         OP_RTYPE: begin ph.push_back(C_EXEC);   ph.push_back(C_NONE); end
         OP_ADDI:  begin ph.push_back(C_ADDIEX); ph.push_back(C_NONE); end
         OP_BEQ:   ph.push_back(C_BRANCH);
         OP_J:     ph.push_back(C_NONE);
         default:  r.trap = 1;
      endcase
      r.cycles = ph.size();
      foreach (ph[i]) r.ctrl_sig = r.ctrl_sig * 31 + ph[i];
      r.ir_writes   = 1;
      r.pc_writes   = 1 + (op == OP_J);
      r.cond_writes = (op == OP_BEQ);
      r.reg_writes  = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_ADDI);
      r.dst_cycles  = (op == OP_RTYPE);
      r.m2r_cycles  = (op == OP_LW);
      r.src_sum     = (op == OP_BEQ) ? 1 : (op == OP_J) ? 2 : 0;
      r.mem_reads   = wf + 1 + ((op == OP_LW) ? wd + 1 : 0);
      r.mem_writes  = (op == OP_SW) ? wd + 1 : 0;
      r.count       = n;
      return r;
   endfunction

   // One cycle = drive right after the rising edge; the monitor samples on the
   // falling edge.
   task automatic idle(input int k, input bit go);
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
         run       = go && (i == k - 1);
         mem_ready = 1'($urandom);
         opcode    = 6'($urandom);
         zero      = 1'($urandom);
      end
   endtask

   // mid_run: 0/1 forces run during non-final cycles, 2 randomizes it.
   // abort_at >= 0 asserts rst in that cycle instead of finishing.
   task automatic drive_instr(input logic [5:0] op, input int wf, input int wd,
                              input bit run_next, input int mid_run, input int abort_at);
      rec_t r;
      int   len, mem_lo, mem_hi;
      bit   is_mem;
      is_mem = (op == OP_LW) || (op == OP_SW);
      mem_lo = wf + 3;
      mem_hi = wf + 3 + wd;
      if (abort_at < 0) begin
         model_n++;
         r = model(op, wf, wd, model_n);
         exp_q.push_back(r);
      end else begin
         r = model(op, wf, wd, 0);
      end
      len = r.cycles;
      for (int c = 0; c < len; c++) begin
         @(posedge clk); #1;
         if (c == abort_at) begin
            rst = 1'b1;
            return;
         end
         if (c == 0) check("fetch_start", {busy, mem_read, i_or_d}, 3'b110);
         opcode = (c <= wf) ? 6'($urandom) : op;
         zero   = 1'($urandom);
         if (c == wf)                                 mem_ready = 1'b1;
         else if (c < wf)                             mem_ready = 1'b0;
         else if (is_mem && c >= mem_lo && c <= mem_hi) mem_ready = (c == mem_hi);
         else                                         mem_ready = 1'($urandom);
         if (c == len - 1)    run = run_next;
         else if (mid_run == 2) run = 1'($urandom);
         else                 run = (mid_run == 1);
      end
   endtask

   initial begin : monitor
      rec_t        acc;
      rec_t        exp;
      bit          in_instr, prev_fetch, trapped, fetch_sig, start;
      int unsigned exp_count;
      logic [15:0] strobes;
      in_instr = 0; prev_fetch = 0; trapped = 0; exp_count = 0;
      acc = '{default: 0};
      forever begin
         @(negedge clk);
         strobes = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                    ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};
         if (rst) begin
            in_instr = 0; prev_fetch = 0; trapped = 0; exp_count = 0;
            check("reset_strobes", strobes, 0);
            check("reset_status", {busy, trap, instr_count}, 0);
            continue;
         end
         fetch_sig  = busy && mem_read && !i_or_d;
         start      = fetch_sig && !prev_fetch;
         prev_fetch = fetch_sig;
         if (in_instr && (start || !busy)) begin
            in_instr  = 0;
            acc.count = instr_count;
            acc.trap  = trap;
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", exp_q.size(), 1);
            end else begin
               exp = exp_q.pop_front();
               check("cycles",      acc.cycles,      exp.cycles);
               check("ir_writes",   acc.ir_writes,   exp.ir_writes);
               check("pc_writes",   acc.pc_writes,   exp.pc_writes);
               check("cond_writes", acc.cond_writes, exp.cond_writes);
               check("reg_writes",  acc.reg_writes,  exp.reg_writes);
               check("reg_dst",     acc.dst_cycles,  exp.dst_cycles);
               check("mem_to_reg",  acc.m2r_cycles,  exp.m2r_cycles);
               check("pc_source",   acc.src_sum,     exp.src_sum);
               check("mem_reads",   acc.mem_reads,   exp.mem_reads);
               check("mem_writes",  acc.mem_writes,  exp.mem_writes);
               check("alu_setup",   acc.ctrl_sig,    exp.ctrl_sig);
               check("instr_count", acc.count,       exp.count);
               check("trap_entry",  acc.trap,        exp.trap);
               exp_count = exp.count;
               trapped   = (exp.trap != 0);
            end
         end
         if (start) begin
            in_instr = 1;
            acc = '{default: 0};
         end
         if (in_instr) begin
            acc.cycles++;
            acc.ir_writes   += ir_write;
            acc.pc_writes   += pc_write;
            acc.cond_writes += pc_write_cond;
            acc.reg_writes  += reg_write;
            acc.dst_cycles  += reg_dst;
            acc.m2r_cycles  += mem_to_reg;
            acc.src_sum     += pc_source;
            acc.mem_reads   += mem_read;
            acc.mem_writes  += mem_write;
            acc.ctrl_sig     = acc.ctrl_sig * 31 + {trap, alu_src_a, alu_src_b, alu_op, i_or_d};
         end else if (!busy) begin
            check("idle_strobes", strobes, 0);
            check("idle_trap", trap, trapped);
            check("idle_count", instr_count, exp_count);
         end else begin
            check("orphan_busy", busy, 0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [5:0] ops[6];
      logic [5:0] op;
      bit         rn;
      ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(3, 1'b1);

      // Directed: R-type, LW with 2 wait states, R-type with run dropped in EXEC.
      drive_instr(OP_RTYPE, 0, 0, 1'b1, 1, -1);
      drive_instr(OP_LW,    0, 2, 1'b1, 1, -1);
      drive_instr(OP_RTYPE, 0, 0, 1'b0, 0, -1);
      idle(2, 1'b1);

      // Random mix of legal instructions, wait states and run behaviour.
      repeat (50) begin
         op = ops[$urandom_range(0, 5)];
         rn = ($urandom_range(0, 3) != 0);
         drive_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rn, 2, -1);
         if (!rn) idle($urandom_range(1, 3), 1'b1);
      end

      // Reset while a store is waiting in MEMWR.
      drive_instr(OP_SW, 0, 6, 1'b1, 1, 5);
      model_n = 0;
      @(posedge clk); #1;
      rst = 1'b0; run = 1'b0;
      idle(3, 1'b1);

      // SW, BEQ, J after reset, then an illegal opcode.
      drive_instr(OP_SW,  1, 1, 1'b1, 2, -1);
      drive_instr(OP_BEQ, 0, 0, 1'b1, 2, -1);
      drive_instr(OP_J,   0, 0, 1'b1, 2, -1);
      drive_instr(6'h3F,  0, 0, 1'b1, 1, -1);
      repeat (10) begin
         @(posedge clk); #1;
         run = 1'b1; mem_ready = 1'($urandom); opcode = 6'($urandom);
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; run = 1'b0;
      idle(3, 1'b0);

      @(posedge clk); #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
